bram_write_sequencer: RTL and testbench
=======================================

BRAM_WRITE_SEQUENCER -- requirements
Module: bram_write_sequencer

Interface
REQ-001 SHALL have parameter WRITE_ADDRESS_MSB_FROM_DATALSB, default 16, giving the wr_data bit position of the 2-bit lane/top-address field.
REQ-002 SHALL have parameter WRITE_ENABLE_FROM_DATA, default 20, giving the wr_data bit position of the active-high write-enable bit.
REQ-003 SHALL have parameter READ_ADDRESS_MSB_FROM_DATALSB, default 24, giving the wr_data bit position of the 2-bit read-lane field.
REQ-004 Ports, in this order:
- clk, input, 1, sole clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- cfg_width, input, 2, element width: 1 = 16-bit, 2 = 8-bit, 0/3 = illegal.
- start, input, 1, begin sequence (IDLE only).
- abort, input, 1, terminate sequence.
- base_idx, input, 10, first element index.
- length, input, 11, number of elements.
- rd_lane, input, 2, passed into the read-lane field.
- s_valid, input, 1, stream beat valid.
- s_ready, output, 1, stream beat accepted when high together with s_valid.
- s_data, input, 16, element data; low 8 bits used in 8-bit mode.
- wr_addr, output, 8, RAM row.
- wr_data, output, 32, packed data plus control fields.
- busy, output, 1, high in RUN.
- done, output, 1, one-cycle completion pulse.
- cfg_err, output, 1, one-cycle pulse on rejected start.
- wrap_err, output, 1, sticky wrap flag.

Function
REQ-005 States SHALL be IDLE and RUN.
- IDLE -> RUN on start with legal cfg_width and length != 0.
- RUN -> IDLE on final beat accept or on abort.
REQ-006 Start in IDLE SHALL latch cfg_width, base_idx, length and rd_lane into internal registers.
REQ-007 Start with illegal cfg_width SHALL stay in IDLE and pulse cfg_err for one cycle.
REQ-008 Start with length == 0 and legal cfg_width SHALL stay in IDLE and pulse done for one cycle.
REQ-009 Start while in RUN SHALL be ignored.
REQ-010 s_ready SHALL be combinational: state == RUN and not abort.
REQ-011 Each accepted beat SHALL register, on the same clock edge, a write with element index e:
- 16-bit mode: wr_addr = e[8:1], lane = {1'b0, e[0]}, wr_data[15:0] = s_data.
- 8-bit mode: wr_addr = e[9:2], lane = e[1:0], wr_data[7:0] = s_data[7:0].
- The lane field is written at WRITE_ADDRESS_MSB_FROM_DATALSB.
- The write-enable bit is 1.
- rd_lane is written at READ_ADDRESS_MSB_FROM_DATALSB.
- All other wr_data bits are 0.
REQ-012 Write latency SHALL be 1 cycle from accept to outputs.
REQ-013 In any cycle without an accepted beat, the write-enable bit SHALL be 0; wr_addr and the other wr_data bits hold their values.
REQ-014 Element index e SHALL start at base_idx and increment by 1 per accept, modulo capacity: 512 in 16-bit mode, 1024 in 8-bit mode.
REQ-015 A remaining-count register SHALL decrement per accept. The accept that brings it to 0 SHALL pulse done in the following cycle and return to IDLE.
REQ-016 Abort in RUN SHALL return to IDLE next cycle without done; no beat is accepted in the abort cycle.
REQ-017 busy SHALL equal (state == RUN).

Reset
REQ-018 rst_n low SHALL asynchronously force:
- state IDLE;
- wr_addr 0, wr_data 0;
- busy 0, done 0, cfg_err 0, wrap_err 0;
- internal index and count registers 0.
REQ-019 Reset mid-sequence SHALL discard the sequence; no done pulse after release.

Configuration
REQ-020 With BRAM_WR_SEQ_WRAP_ERR_EN defined:
- wrap_err SHALL set when an accepted beat advances e from capacity-1 to 0.
- It SHALL stay set until the next accepted start.
REQ-021 Without BRAM_WR_SEQ_WRAP_ERR_EN, wrap_err SHALL be constant 0 and the port SHALL remain present.

Verification
REQ-022 8-bit mode, base_idx 0, length 4, s_data 0x11..0x44 back-to-back:
- wr_addr 0 on all four writes;
- lanes 0..3;
- WE bit 1 for four cycles;
- done pulses the cycle after the last write.
REQ-023 16-bit mode, base_idx 5, length 3, s_valid gapped:
- rows 2, 3, 3;
- lanes 1, 0, 1;
- WE bit 0 on gap cycles.
REQ-024 16-bit mode, base_idx 511, length 2, macro defined:
- second write at row 0, lane 0;
- wrap_err = 1 until the next start.
- With the macro undefined, wrap_err stays 0.
REQ-025 Abort asserted with s_valid high after 2 of 8 beats:
- s_ready 0 in the abort cycle;
- no further writes;
- no done; busy 0 next cycle.
REQ-026 Start with cfg_width 0:
- cfg_err pulses one cycle;
- busy stays 0.
- Then rst_n pulsed low mid-RUN: all outputs 0 immediately, no done.

Source files
------------

// File: rtl/bram_write_sequencer.sv
// Streams 8/16-bit elements into a 32-bit-wide BRAM write port, packing lane, write-enable and read-lane fields into wr_data.
// Optional sticky index-wrap flag enabled by defining BRAM_WR_SEQ_WRAP_ERR_EN.
module bram_write_sequencer #(
    parameter int WRITE_ADDRESS_MSB_FROM_DATALSB = 16,
    parameter int WRITE_ENABLE_FROM_DATA         = 20,
    parameter int READ_ADDRESS_MSB_FROM_DATALSB  = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  cfg_width,
    input  logic        start,
    input  logic        abort,
    input  logic [9:0]  base_idx,
    input  logic [10:0] length,
    input  logic [1:0]  rd_lane,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    output logic [7:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        cfg_err,
    output logic        wrap_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q;
    logic        mode8_q;
    logic [9:0]  idx_q;
    logic [10:0] cnt_q;
    logic [1:0]  rdLane_q;
    logic [7:0]  wr_addr_q;
    logic [31:0] wr_data_q;
    logic        done_q;
    logic        cfg_err_q;

    logic        accept;
    logic        startLegal;
    logic        lastBeat;
    logic [9:0]  idx_d;
    logic [9:0]  idxNext;
    logic [7:0]  wr_addr_d;
    logic [1:0]  lane;
    logic [31:0] wr_data_d;

    assign s_ready = (state_q == RUN) && !abort;
    assign busy    = (state_q == RUN);
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

    // 16-bit mode keeps the index inside 512 elements, so bit 9 is forced low there.
    always_comb begin
        accept     = s_ready && s_valid;
        startLegal = (cfg_width == 2'd1) || (cfg_width == 2'd2);
        lastBeat   = (cnt_q == 11'd1);
        idx_d      = (cfg_width == 2'd2) ? base_idx : {1'b0, base_idx[8:0]};
        idxNext    = mode8_q ? (idx_q + 10'd1) : {1'b0, idx_q[8:0] + 9'd1};
        if (mode8_q) begin
            wr_addr_d = idx_q[9:2];
            lane      = idx_q[1:0];
        end else begin
            wr_addr_d = idx_q[8:1];
            lane      = {1'b0, idx_q[0]};
        end
        wr_data_d = '0;
        if (mode8_q) begin
            wr_data_d[7:0] = s_data[7:0];
        end else begin
            wr_data_d[15:0] = s_data;
        end
        wr_data_d[WRITE_ADDRESS_MSB_FROM_DATALSB +: 2] = lane;
        wr_data_d[WRITE_ENABLE_FROM_DATA]              = 1'b1;
        wr_data_d[READ_ADDRESS_MSB_FROM_DATALSB +: 2]  = rdLane_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode8_q   <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
            rdLane_q  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            wr_data_q[WRITE_ENABLE_FROM_DATA] <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode8_q  <= (cfg_width == 2'd2);
                        idx_q    <= idx_d;
                        cnt_q    <= length;
                        rdLane_q <= rd_lane;
                        if (!startLegal) begin
                            cfg_err_q <= 1'b1;
                        end else if (length == 11'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (accept) begin
                        wr_addr_q <= wr_addr_d;
                        wr_data_q <= wr_data_d;
                        idx_q     <= idxNext;
                        cnt_q     <= cnt_q - 11'd1;
                        if (lastBeat) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef BRAM_WR_SEQ_WRAP_ERR_EN
    logic wrap_err_q;
    logic wrapHit;

    assign wrapHit  = accept && (mode8_q ? (idx_q == 10'h3FF) : (idx_q[8:0] == 9'h1FF));
    assign wrap_err = wrap_err_q;

    // Sticky until a start with a legal width is taken in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_err_q <= 1'b0;
        end else if ((state_q == IDLE) && start && startLegal) begin
            wrap_err_q <= 1'b0;
        end else if (wrapHit) begin
            wrap_err_q <= 1'b1;
        end
    end
`else
    assign wrap_err = 1'b0;
`endif

endmodule

// File: tb/tb_bram_write_sequencer.sv
// Self-checking bench for bram_write_sequencer: a scoreboard of expected writes is filled as beats are driven
// and drained by a monitor whenever the write-enable bit appears.
module tb_bram_write_sequencer;

    localparam int WA = 16;
    localparam int WE = 20;
    localparam int RA = 24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cfg_width = 2'd0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [9:0]  base_idx = '0;
    logic [10:0] length = '0;
    logic [1:0]  rd_lane = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic        wrap_err;

    bram_write_sequencer #(
        .WRITE_ADDRESS_MSB_FROM_DATALSB(WA),
        .WRITE_ENABLE_FROM_DATA(WE),
        .READ_ADDRESS_MSB_FROM_DATALSB(RA)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_width(cfg_width),
        .start(start),
        .abort(abort),
        .base_idx(base_idx),
        .length(length),
        .rd_lane(rd_lane),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy(busy),
        .done(done),
        .cfg_err(cfg_err),
        .wrap_err(wrap_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t expQ[$];
    wr_t monW;
    int  checks = 0;
    int  errors = 0;

    bit         mRun = 0;
    bit         mMode8 = 0;
    int         mIdx = 0;
    int         mCnt = 0;
    logic [1:0] mRdl = '0;
    bit         mWrap = 0;

    function automatic wr_t modelWrite(bit m8, int e, logic [15:0] d, logic [1:0] rl);
        wr_t w;
        logic [9:0] ev;
        logic [1:0] ln;
        ev = e[9:0];
        w.data = '0;
        if (m8) begin
            w.addr = ev[9:2];
            ln = ev[1:0];
            w.data[7:0] = d[7:0];
        end else begin
            w.addr = ev[8:1];
            ln = {1'b0, ev[0]};
            w.data[15:0] = d;
        end
        w.data[WA +: 2] = ln;
        w.data[WE] = 1'b1;
        w.data[RA +: 2] = rl;
        return w;
    endfunction

    function automatic logic expWrap();
`ifdef BRAM_WR_SEQ_WRAP_ERR_EN
        return mWrap;
`else
        return 1'b0;
`endif
    endfunction

    // Drains the scoreboard whenever a write is presented.
    always @(posedge clk) begin
        #1;
        if (wr_data[WE] === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got addr=%h data=%h, expected no write", wr_addr, wr_data);
            end else begin
                monW = expQ.pop_front();
                if (wr_addr !== monW.addr || wr_data !== monW.data) begin
                    errors++;
                    $display("[TB] FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                             wr_addr, wr_data, monW.addr, monW.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic startSeq(input logic [1:0] w, input logic [9:0] b, input logic [10:0] len, input logic [1:0] rl);
        bit legal;
        bit eCfg;
        bit eDone;
        legal = (w == 2'd1) || (w == 2'd2);
        eCfg = 0;
        eDone = 0;
        cfg_width = w;
        base_idx = b;
        length = len;
        rd_lane = rl;
        start = 1'b1;
        s_valid = 1'b0;
        abort = 1'b0;
        if (!mRun) begin
            if (!legal) begin
                eCfg = 1;
            end else begin
                mWrap = 0;
                if (len == 0) begin
                    eDone = 1;
                end else begin
                    mRun = 1;
                    mMode8 = (w == 2'd2);
                    mIdx = int'(b) % (mMode8 ? 1024 : 512);
                    mCnt = int'(len);
                    mRdl = rl;
                end
            end
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (cfg_err !== eCfg) begin
            errors++;
            $display("[TB] FAIL start_cfg_err: got %b expected %b", cfg_err, eCfg);
        end
        checks++;
        if (done !== eDone) begin
            errors++;
            $display("[TB] FAIL start_done: got %b expected %b", done, eDone);
        end
        checks++;
        if (busy !== mRun) begin
            errors++;
            $display("[TB] FAIL start_busy: got %b expected %b", busy, mRun);
        end
    endtask

    task automatic beat(input logic v, input logic [15:0] d, input logic ab);
        bit runBefore;
        bit eDone;
        bit took;
        runBefore = mRun;
        eDone = 0;
        took = 0;
        s_valid = v;
        s_data = d;
        abort = ab;
        if (mRun) begin
            if (ab) begin
                mRun = 0;
            end else if (v) begin
                took = 1;
                expQ.push_back(modelWrite(mMode8, mIdx, d, mRdl));
                if (mIdx == (mMode8 ? 1023 : 511)) mWrap = 1;
                mIdx = (mIdx + 1) % (mMode8 ? 1024 : 512);
                mCnt--;
                if (mCnt == 0) begin
                    mRun = 0;
                    eDone = 1;
                end
            end
        end
        #1;
        checks++;
        if (s_ready !== (runBefore && !ab)) begin
            errors++;
            $display("[TB] FAIL s_ready: got %b expected %b", s_ready, runBefore && !ab);
        end
        @(negedge clk);
        checks++;
        if (done !== eDone) begin
            errors++;
            $display("[TB] FAIL done: got %b expected %b", done, eDone);
        end
        checks++;
        if (busy !== mRun) begin
            errors++;
            $display("[TB] FAIL busy: got %b expected %b", busy, mRun);
        end
        checks++;
        if (wrap_err !== expWrap()) begin
            errors++;
            $display("[TB] FAIL wrap_err: got %b expected %b", wrap_err, expWrap());
        end
        if (!took) begin
            checks++;
            if (wr_data[WE] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL we_idle: got %b expected 0", wr_data[WE]);
            end
        end
        s_valid = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({wr_addr, wr_data, busy, done, cfg_err, wrap_err, s_ready} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got addr=%h data=%h busy=%b done=%b cfg_err=%b wrap=%b rdy=%b, expected all 0",
                     wr_addr, wr_data, busy, done, cfg_err, wrap_err, s_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_8bit_back_to_back();
        startSeq(2'd2, 10'd0, 11'd4, 2'd3);
        beat(1'b1, 16'hAA11, 1'b0);
        beat(1'b1, 16'hBB22, 1'b0);
        beat(1'b1, 16'hCC33, 1'b0);
        beat(1'b1, 16'hDD44, 1'b0);
        beat(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_16bit_gapped();
        startSeq(2'd1, 10'd5, 11'd3, 2'd1);
        beat(1'b1, 16'hA1A1, 1'b0);
        beat(1'b0, 16'hFFFF, 1'b0);
        beat(1'b1, 16'hB2B2, 1'b0);
        beat(1'b0, 16'h0000, 1'b0);
        beat(1'b0, 16'h5555, 1'b0);
        beat(1'b1, 16'hC3C3, 1'b0);
        beat(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_wrap();
        startSeq(2'd1, 10'd511, 11'd2, 2'd2);
        beat(1'b1, 16'h1234, 1'b0);
        beat(1'b1, 16'h5678, 1'b0);
        repeat (3) beat(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_abort();
        startSeq(2'd2, 10'd100, 11'd8, 2'd2);
        beat(1'b1, 16'h0101, 1'b0);
        beat(1'b1, 16'h0202, 1'b0);
        beat(1'b1, 16'h0303, 1'b1);
        repeat (3) beat(1'b1, 16'h0404, 1'b0);
    endtask

    task automatic test_cfg_and_zero_len();
        startSeq(2'd0, 10'd0, 11'd4, 2'd0);
        beat(1'b1, 16'h0000, 1'b0);
        startSeq(2'd3, 10'd0, 11'd4, 2'd0);
        startSeq(2'd1, 10'd0, 11'd0, 2'd0);
        beat(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_start_in_run();
        startSeq(2'd1, 10'd10, 11'd3, 2'd0);
        beat(1'b1, 16'h7001, 1'b0);
        startSeq(2'd2, 10'd900, 11'd9, 2'd3);
        beat(1'b1, 16'h7002, 1'b0);
        beat(1'b1, 16'h7003, 1'b0);
        beat(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        startSeq(2'd1, 10'd20, 11'd5, 2'd1);
        beat(1'b1, 16'h9001, 1'b0);
        beat(1'b1, 16'h9002, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wr_addr, wr_data, busy, done, cfg_err, wrap_err} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: got addr=%h data=%h busy=%b done=%b cfg_err=%b wrap=%b, expected all 0",
                     wr_addr, wr_data, busy, done, cfg_err, wrap_err);
        end
        mRun = 0;
        mWrap = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) beat(1'b1, 16'h9003, 1'b0);
    endtask

    initial begin
        test_reset();
        test_8bit_back_to_back();
        test_16bit_gapped();
        test_wrap();
        test_abort();
        test_cfg_and_zero_len();
        test_start_in_run();
        test_reset_mid_run();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_writes: got %0d outstanding expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
